// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache miss-handling path.
package cache_pkg;

  localparam int ADDR_W = 10;
  localparam int OFFS_W = 4;
  localparam int SET_W  = 1;
  localparam int LINE_W = 128;
  localparam int TAG_W  = ADDR_W - OFFS_W - SET_W;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FILL,
    DONE,
    ERR
  } state_e;

  function automatic int tag_width(input int addr_w, input int offs_w, input int set_w);
    return addr_w - offs_w - set_w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: optional victim writeback, line refill, per-request timeout,
// with all outputs registered from the next state.
module cache_miss_ctrl #(
  parameter int ADDR_W  = cache_pkg::ADDR_W,
  parameter int OFFS_W  = cache_pkg::OFFS_W,
  parameter int SET_W   = cache_pkg::SET_W,
  parameter int LINE_W  = cache_pkg::LINE_W,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16,
  localparam int TAG_W  = cache_pkg::tag_width(ADDR_W, OFFS_W, SET_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [LINE_W-1:0] victim_data,
  output logic              miss_done,
  output logic              miss_err,
  output logic              fill_valid,
  output logic [LINE_W-1:0] fill_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt,
  output logic              busy
);

  import cache_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] vdata_q, vdata_d;
  logic [LINE_W-1:0] fill_d;
  logic              miss_inc, wb_inc;

  logic              req_d, we_d, done_d, err_d, fv_d, busy_d;
  logic [ADDR_W-1:0] maddr_d;
  logic [LINE_W-1:0] wdata_d;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    tag_d    = tag_q;
    vdata_d  = vdata_q;
    fill_d   = fill_data;
    miss_inc = 1'b0;
    wb_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (miss_valid) begin
          addr_d   = miss_addr;
          tag_d    = victim_tag;
          vdata_d  = victim_data;
          miss_inc = 1'b1;
          wait_d   = '0;
          state_d  = miss_dirty ? WB : FILL;
        end
      end
      WB: begin
        // An ack on the limit cycle still completes the request.
        if (mem_ack) begin
          wb_inc  = 1'b1;
          wait_d  = '0;
          state_d = FILL;
        end else if (wait_q == LIMIT) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_d  = mem_rdata;
          state_d = DONE;
        end else if (wait_q == LIMIT) begin
          state_d = ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it after the edge.
  always_comb begin
    req_d   = (state_d == WB) || (state_d == FILL);
    we_d    = (state_d == WB);
    done_d  = (state_d == DONE) || (state_d == ERR);
    err_d   = (state_d == ERR);
    fv_d    = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    maddr_d = '0;
    wdata_d = '0;
    if (state_d == WB) begin
      maddr_d = {tag_d, addr_d[OFFS_W+SET_W-1:OFFS_W], {OFFS_W{1'b0}}};
      wdata_d = vdata_d;
    end else if (state_d == FILL) begin
      maddr_d = {addr_d[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
    end
  end

  // NOTE: the wide victim/fill registers are reset as well, so nothing visible ever carries X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      tag_q      <= '0;
      vdata_q    <= '0;
      fill_data  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      miss_done  <= 1'b0;
      miss_err   <= 1'b0;
      fill_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      tag_q      <= tag_d;
      vdata_q    <= vdata_d;
      fill_data  <= fill_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= maddr_d;
      mem_wdata  <= wdata_d;
      miss_done  <= done_d;
      miss_err   <= err_d;
      fill_valid <= fv_d;
      busy       <= busy_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc),
    .clr   (stat_clr),
    .cnt   (miss_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wb_inc),
    .clr   (stat_clr),
    .cnt   (wb_cnt)
  );

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: directed misses, expected memory
// requests and completions queued by the stimulus, checked by a monitor.
module tb_cache_miss_ctrl;

  localparam int ADDR_W  = 10;
  localparam int TAG_W   = 5;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;

  logic              clk, rst_n;
  logic              miss_valid, miss_dirty, stat_clr, mem_ack;
  logic [ADDR_W-1:0] miss_addr;
  logic [TAG_W-1:0]  victim_tag;
  logic [LINE_W-1:0] victim_data, mem_rdata;
  logic              miss_done, miss_err, fill_valid, mem_req, mem_we, busy;
  logic [LINE_W-1:0] fill_data, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  miss_cnt, wb_cnt;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    int                cycles;
  } mem_exp_t;

  typedef struct {
    int                cyc;
    logic              err;
    logic              fv;
    logic [LINE_W-1:0] data;
  } done_exp_t;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  int        ack_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_seen = 0;
  logic [LINE_W-1:0] rd_data;
  logic [LINE_W-1:0] last_fill;

  cache_miss_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .miss_dirty  (miss_dirty),
    .victim_tag  (victim_tag),
    .victim_data (victim_data),
    .miss_done   (miss_done),
    .miss_err    (miss_err),
    .fill_valid  (fill_valid),
    .fill_data   (fill_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .stat_clr    (stat_clr),
    .miss_cnt    (miss_cnt),
    .wb_cnt      (wb_cnt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: acks each request after the delay queued for it (-1 = never).
  initial begin
    int age;
    int lim;
    bit ack_last;
    age = 0;
    lim = -1;
    ack_last = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req || ack_last) age = 0;
      ack_last = 1'b0;
      if (mem_req) begin
        if (age == 0) lim = (ack_q.size() > 0) ? ack_q.pop_front() : -1;
        if (age == lim) begin
          mem_ack   = 1'b1;
          mem_rdata = rd_data;
          ack_last  = 1'b1;
        end
        age++;
      end
    end
  end

  // Monitor: compares live requests and completion pulses against the queues.
  initial begin
    int hc;
    bit active;
    done_exp_t d;
    hc = 0;
    active = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mem_req) begin
        if (mem_q.size() == 0) begin
          check("mem_req_unexpected", mem_req, 1'b0);
        end else begin
          hc++;
          active = 1'b1;
          check("mem_we", mem_we, mem_q[0].we);
          check("mem_addr", mem_addr, mem_q[0].addr);
          if (mem_q[0].we) check("mem_wdata", mem_wdata, mem_q[0].wdata);
          if (mem_ack) begin
            check("req_cycles", hc, mem_q[0].cycles);
            void'(mem_q.pop_front());
            hc = 0;
            active = 1'b0;
          end
        end
      end else if (active) begin
        check("req_cycles", hc, mem_q[0].cycles);
        void'(mem_q.pop_front());
        hc = 0;
        active = 1'b0;
      end
      if (miss_done) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", miss_done, 1'b0);
        end else begin
          d = done_q.pop_front();
          check("done_cyc", cyc, d.cyc);
          check("miss_err", miss_err, d.err);
          check("fill_valid", fill_valid, d.fv);
          check("fill_data", fill_data, d.data);
        end
        done_seen++;
      end else if (fill_valid || miss_err) begin
        check("pulse_without_done", {fill_valid, miss_err}, 2'b00);
      end
    end
  end

  // Issues one miss at negedge+2 and waits for its completion. Ack delay -1 = never.
  // Done is expected in the cycle after the last request cycle.
  task automatic run_miss(input logic [ADDR_W-1:0] addr, input logic dirty, input logic [TAG_W-1:0] vtag,
                          input logic [LINE_W-1:0] vdata, input logic [LINE_W-1:0] rdata,
                          input int wb_ack, input int fill_ack,
                          input logic [ADDR_W-1:0] wb_addr, input logic [ADDR_W-1:0] fill_addr,
                          input bit clr, input bit stray);
    mem_exp_t  m;
    done_exp_t d;
    int t;
    int start;
    miss_valid  = 1'b1;
    miss_addr   = addr;
    miss_dirty  = dirty;
    victim_tag  = vtag;
    victim_data = vdata;
    rd_data     = rdata;
    stat_clr    = clr;
    t = cyc + 1;
    if (dirty) begin
      ack_q.push_back(wb_ack);
      m.we = 1'b1; m.addr = wb_addr; m.wdata = vdata; m.cycles = wb_ack + 1;
      mem_q.push_back(m);
      t += wb_ack + 1;
    end
    ack_q.push_back(fill_ack);
    m.we = 1'b0; m.addr = fill_addr; m.wdata = '0;
    m.cycles = (fill_ack < 0) ? TIMEOUT : fill_ack + 1;
    mem_q.push_back(m);
    t += m.cycles;
    d.cyc  = t;
    d.err  = (fill_ack < 0);
    d.fv   = !d.err;
    d.data = d.err ? last_fill : rdata;
    if (!d.err) last_fill = rdata;
    done_q.push_back(d);
    start = done_seen;
    @(negedge clk); #2;
    stat_clr = 1'b0;
    for (int i = 0; i < 40 && done_seen == start; i++) begin
      @(negedge clk); #2;
    end
    if (done_seen == start) check("done_wait_expired", done_seen, start + 1);
    if (stray) mem_ack = 1'b1;
    miss_valid = 1'b0;
    @(negedge clk); #2;
  endtask

  localparam logic [LINE_W-1:0] R1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LINE_W-1:0] AA = {16{8'hAA}};
  localparam logic [LINE_W-1:0] R2 = {16{8'h55}};
  localparam logic [LINE_W-1:0] R3 = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [LINE_W-1:0] R4 = 128'hDEADBEEFCAFEF00D1122334455667788;
  localparam logic [LINE_W-1:0] R5 = 128'h00000000FFFFFFFF00000000FFFFFFFF;

  initial begin
    logic [ADDR_W-1:0] la [4];
    logic [ADDR_W-1:0] lf [4];
    mem_exp_t m;
    la = '{10'h3F7, 10'h08C, 10'h1E1, 10'h26A};
    lf = '{10'h3F0, 10'h080, 10'h1E0, 10'h260};
    rst_n = 1'b0;
    miss_valid = 1'b0; miss_dirty = 1'b0; stat_clr = 1'b0;
    miss_addr = '0; victim_tag = '0; victim_data = '0;
    rd_data = '0; last_fill = '0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_miss_done", miss_done, 1'b0);
    check("rst_fill_valid", fill_valid, 1'b0);
    check("rst_fill_data", fill_data, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_miss_cnt", miss_cnt, 2'd0);
    check("rst_wb_cnt", wb_cnt, 2'd0);
    rst_n = 1'b1;
    @(negedge clk); #2;

    // Stray ack while idle.
    mem_ack = 1'b1;
    @(negedge clk); #2;
    check("stray_idle_busy", busy, 1'b0);
    check("stray_idle_req", mem_req, 1'b0);
    check("stray_idle_miss_cnt", miss_cnt, 2'd0);
    check("stray_idle_wb_cnt", wb_cnt, 2'd0);

    // Clean miss, ack in first cycle.
    run_miss(10'h2A4, 1'b0, 5'h00, '0, R1, 0, 0, 10'h000, 10'h2A0, 1'b0, 1'b0);
    check("clean_miss_cnt", miss_cnt, 2'd1);
    check("clean_wb_cnt", wb_cnt, 2'd0);

    // Dirty miss, both acks first cycle, stray ack during DONE.
    run_miss(10'h0F8, 1'b1, 5'h13, AA, R2, 0, 0, 10'h270, 10'h0F0, 1'b0, 1'b1);
    check("dirty_miss_cnt", miss_cnt, 2'd2);
    check("dirty_wb_cnt", wb_cnt, 2'd1);
    check("stray_done_busy", busy, 1'b0);

    // Fill never acked: timeout after exactly TIMEOUT request cycles.
    run_miss(10'h155, 1'b0, 5'h00, '0, R3, 0, -1, 10'h000, 10'h150, 1'b0, 1'b0);
    check("timeout_miss_cnt", miss_cnt, 2'd3);
    check("timeout_fill_kept", fill_data, R2);

    // Ack on the limit cycle wins; miss counter already saturated.
    run_miss(10'h3C0, 1'b0, 5'h00, '0, R4, 0, 3, 10'h000, 10'h3C0, 1'b0, 1'b0);
    check("limit_ack_miss_cnt", miss_cnt, 2'd3);
    check("limit_ack_wb_cnt", wb_cnt, 2'd1);

    // Dirty miss with delayed acks.
    run_miss(10'h21C, 1'b1, 5'h0A, R3, R5, 2, 1, 10'h150, 10'h210, 1'b0, 1'b0);
    check("delayed_wb_cnt", wb_cnt, 2'd2);

    // Reset while waiting in WB.
    miss_valid = 1'b1; miss_addr = 10'h0F8; miss_dirty = 1'b1;
    victim_tag = 5'h13; victim_data = AA;
    ack_q.push_back(-1);
    m.we = 1'b1; m.addr = 10'h270; m.wdata = AA; m.cycles = 2;
    mem_q.push_back(m);
    @(negedge clk); #2;
    @(negedge clk); #2;
    check("wb_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_wb_mem_req", mem_req, 1'b0);
    check("rst_wb_busy", busy, 1'b0);
    check("rst_wb_miss_cnt", miss_cnt, 2'd0);
    check("rst_wb_wb_cnt", wb_cnt, 2'd0);
    miss_valid = 1'b0;
    last_fill = '0;
    ack_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); #2;
    run_miss(10'h004, 1'b0, 5'h00, '0, R5, 0, 0, 10'h000, 10'h000, 1'b0, 1'b0);
    check("post_rst_miss_cnt", miss_cnt, 2'd1);

    // Four more misses: count saturates at 3.
    for (int i = 0; i < 4; i++) begin
      run_miss(la[i], 1'b0, 5'h00, '0, R1 ^ LINE_W'(i), 0, 0, 10'h000, lf[i], 1'b0, 1'b0);
      check("sat_miss_cnt", miss_cnt, (i + 2 > 3) ? 2'd3 : CNT_W'(i + 2));
    end

    // Clear coincident with a miss acceptance wins.
    run_miss(10'h111, 1'b0, 5'h00, '0, R2, 0, 0, 10'h000, 10'h110, 1'b1, 1'b0);
    check("clr_miss_cnt", miss_cnt, 2'd0);
    check("clr_wb_cnt", wb_cnt, 2'd0);
    run_miss(10'h222, 1'b0, 5'h00, '0, R4, 0, 0, 10'h000, 10'h220, 1'b0, 1'b0);
    check("after_clr_miss_cnt", miss_cnt, 2'd1);

    repeat (3) @(negedge clk);
    #2;
    check("done_q_drained", done_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_miss_ctrl.md
# cache_miss_ctrl

Clocked miss-handling sequencer between the 2-way write-back cache and the 128-bit main memory. On a miss it writes the dirty victim line back if needed, fetches the refill line, and returns it to the cache. It replaces the cache's `#1` delay-based miss path with a real handshake and per-state timeout. It also keeps saturating miss and writeback counters for performance runs.

## Interface
Parameters:
- ADDR_W, 10, byte address width
- OFFS_W, 4, line offset bits (16-byte line)
- SET_W, 1, set index bits; TAG_W = ADDR_W-OFFS_W-SET_W
- LINE_W, 128, line width
- TIMEOUT, 255, max cycles waiting for mem_ack per request (≥1)
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- miss_valid  in  1  cache has a pending miss; level, held until miss_done
- miss_addr  in  ADDR_W  missing byte address
- miss_dirty  in  1  selected victim way is valid and dirty
- victim_tag  in  TAG_W  victim line tag
- victim_data  in  LINE_W  victim line contents
- miss_done  out  1  one-cycle pulse: miss handled
- miss_err  out  1  coincides with miss_done when a timeout occurred
- fill_valid  out  1  one-cycle pulse with miss_done on success; fill_data valid
- fill_data  out  LINE_W  registered refill line
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = line write, 0 = line read
- mem_addr  out  ADDR_W  line-aligned address (low OFFS_W bits zero)
- mem_wdata  out  LINE_W  writeback data
- mem_rdata  in  LINE_W  read data, valid with mem_ack on reads
- mem_ack  in  1  one-cycle completion strobe
- stat_clr  in  1  synchronous clear of counters
- miss_cnt  out  CNT_W  saturating count of accepted misses
- wb_cnt  out  CNT_W  saturating count of completed writebacks
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, WB, FILL, DONE, ERR.
- IDLE: miss_valid sampled high → latch miss_addr, victim_tag, victim_data, miss_dirty; miss_cnt+1; go to WB if dirty, else FILL.
- WB: mem_req=1, mem_we=1, mem_addr={victim_tag, miss_addr set bits, OFFS_W'b0}, mem_wdata=latched victim. mem_ack → wb_cnt+1, go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={miss_addr[ADDR_W-1:OFFS_W], OFFS_W'b0}. mem_ack → capture mem_rdata into fill_data, go to DONE.
- DONE: miss_done=1, fill_valid=1 for one cycle → IDLE.
- ERR: miss_done=1, miss_err=1, fill_valid=0 for one cycle → IDLE; fill_data unchanged.
- Timeout: wait counter clears on entry to WB/FILL and increments each cycle without mem_ack. If it reaches TIMEOUT with no ack, go to ERR and drop mem_req. An ack in the same cycle as the limit wins.
- mem_ack outside WB/FILL is ignored.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Counters saturate at all-ones. stat_clr has priority over an increment in the same cycle.
- Reset values: all outputs 0, state IDLE, counters 0, fill_data 0.
- Reset mid-operation drops mem_req immediately (asynchronous). The in-flight miss is abandoned; the cache re-issues it.

## Timing
- All outputs are registered.
- mem_req rises the cycle after miss_valid is sampled.
- mem_ack may arrive in the first mem_req cycle. mem_req falls the cycle after the ack edge.
- Clean miss, ack in first cycle: miss_done 2 cycles after the sampling edge.
- Dirty miss, both acks in first cycle: miss_done 3 cycles after the sampling edge.
- The cache must drop miss_valid on the edge ending the DONE/ERR cycle. A new miss can be sampled in the following IDLE cycle (1 idle cycle minimum between misses).
- Timeout: ERR is entered after exactly TIMEOUT mem_req-high cycles without ack.

## Structure
- Shared package cache_pkg holds:
  - state enum (IDLE, WB, FILL, DONE, ERR);
  - default constants ADDR_W, OFFS_W, SET_W, LINE_W;
  - TAG_W derivation.
- One natural sub-module, sat_counter (CNT_W, inc, clr), instantiated for miss_cnt and wb_cnt.
- The FSM and the wait counter stay in the top module.

## Test plan
- Clean miss: miss_addr=0x2A4, miss_dirty=0, ack first cycle, mem_rdata=0x0123…CDEF → read at mem_addr=0x2A0; miss_done+fill_valid 2 cycles after sample; fill_data=0x0123…CDEF; miss_cnt=1, wb_cnt=0.
- Dirty miss: victim_tag=0x13, miss_addr=0x0F8, victim_data=0xAA…AA → write at mem_addr=0x270 with wdata 0xAA…AA, then read at 0x0F0; done after 3 cycles; wb_cnt=1.
- Timeout: TIMEOUT=4, no ack in FILL → mem_req high exactly 4 cycles; miss_done=miss_err=1, fill_valid=0; ack arriving on the 4th cycle instead → normal completion.
- Reset mid-WB: rst_n low during WB → mem_req, busy and counters 0 immediately. After release, a new clean miss completes normally.
- Counter saturation and clear: CNT_W=2, 5 misses → miss_cnt=3; stat_clr together with a miss acceptance → miss_cnt=0.
- Stray ack: mem_ack pulses in IDLE and DONE → no state change, no counter change.
